datamover_tcdm_responder: RTL
=============================

Name: datamover_tcdm_responder

Overview:
- Synthesizable TCDM-side responder: the target end of the HCI core TCDM protocol issued by the datamover streamer.
- Serves loads and stores from a local word array, with a fixed, configurable response latency.
- Can inject periodic grant stalls and spurious write r_valid strobes, reproducing cluster TCDM behaviour.
- Used as the memory endpoint in standalone datamover benches and as a scratch target in FPGA bring-up.

Parameters:
- BW, 32: data width in bits; multiple of 32.
- AW, 32: byte address width.
- MEM_WORDS, 1024: number of BW-wide words; power of two.
- LATENCY, 1: cycles from accepted request to r_valid; legal range 1..4.
- GNT_STALL_EVERY, 0: 0 = never stall; N>0 = drop gnt for 1 cycle after every N accepted requests.
- WRITE_RVALID, 0: 1 = stores also produce an r_valid pulse (r_data = 0).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- clear_i  in  1  synchronous soft clear
- enable_i  in  1  gates grant
- tcdm_req_i  in  1  request
- tcdm_gnt_o  out  1  grant
- tcdm_add_i  in  AW  byte address
- tcdm_wen_i  in  1  1 = load, 0 = store
- tcdm_be_i  in  BW/8  byte enables (stores only)
- tcdm_data_i  in  BW  store data
- tcdm_r_data_o  out  BW  load data
- tcdm_r_valid_o  out  1  response strobe
- busy_o  out  1  response in flight
- err_o  out  1  sticky out-of-range flag

Behaviour:
- Reset (rst_i high, async):
  - Response pipeline valid bits, r_data_o, stall state, stall counter and err_o go to 0.
  - Array contents are not reset.
  - Reset mid-transaction discards all in-flight responses; no r_valid is produced for them.
- Grant: tcdm_gnt_o = enable_i & ~stall_q, combinational.
  - A request is accepted on a cycle with req & gnt.
  - No r_ready exists; responses are never back-pressured.
- Addressing:
  - word index = tcdm_add_i >> log2(BW/8); the low log2(BW/8) bits are ignored.
  - Index >= MEM_WORDS is out of range:
    - a store is dropped;
    - a load returns 0;
    - err_o is set at the next edge and holds until clear_i or reset.
- Store:
  - Bytes with be=1 are written at the accepting edge; bytes with be=0 are unchanged.
  - be=0 on every byte is a legal no-op.
- Load:
  - The array is read at the accepting edge and the data enters response pipeline stage 0.
  - r_valid_o and r_data_o appear exactly LATENCY cycles after the accept cycle (LATENCY=1: the next cycle).
  - r_data_o holds its last value while r_valid_o is 0.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the new data. Single port, so one access per cycle.
- WRITE_RVALID=1: every accepted store pushes a pipeline entry with data 0, so r_valid pulses LATENCY cycles later. With 0, stores produce no response.
- Back-to-back accepts give one r_valid per accepted load, in order, with no bubbles added.
- Stall generator (GNT_STALL_EVERY=N>0):
  - The counter increments on each accept.
  - On the accept that brings the count to N: counter returns to 0 and stall_q=1 for exactly the next cycle.
  - stall_q clears automatically after 1 cycle.
- enable_i=0: gnt is 0 and no new accepts occur, but the pipeline keeps draining normally.
- clear_i=1:
  - At the next edge: pipeline valid bits, stall_q, counter and err_o are zeroed.
  - Array contents are kept.
  - While clear_i is high gnt is forced to 0, so no request is accepted in that cycle.
- busy_o = OR of all pipeline valid bits.

Test Plan:
- Store BW=32, add 0x10, data 0xDEADBEEF, be=0xF; then load 0x10 (LATENCY=1) -> r_valid exactly 1 cycle after the load accept, r_data=0xDEADBEEF; no r_valid after the store.
- Store 0x11223344 to 0x20; then store 0xAABBCCDD with be=0x5; load 0x20 -> 0x11BB33DD. Load 0x23 -> same word.
- LATENCY=3: 4 back-to-back loads of words holding 1,2,3,4 -> r_valid high for 4 consecutive cycles starting 3 cycles after the first accept, data 1,2,3,4.
- GNT_STALL_EVERY=2, req held high for 6 cycles -> gnt pattern 1,1,0,1,1,0; 4 accepts.
- WRITE_RVALID=1, LATENCY=2: a single store -> r_valid pulse 2 cycles later with r_data=0; busy_o high for those 2 cycles.
- MEM_WORDS=1024, load 0x1000 -> r_data=0, err_o=1 sticky. Assert clear_i with 2 loads in flight -> no r_valid, err_o=0, earlier stored data still readable. Assert rst_i mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/datamover_tcdm_responder.sv
// TCDM target endpoint for the datamover streamer: a local word array served with a fixed
// response latency, plus optional periodic grant stalls and store acknowledgements.
module datamover_tcdm_responder #(
    parameter int unsigned BW              = 32,
    parameter int unsigned AW              = 32,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned GNT_STALL_EVERY = 0,
    parameter int unsigned WRITE_RVALID    = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            enable_i,
    input  logic            tcdm_req_i,
    output logic            tcdm_gnt_o,
    input  logic [AW-1:0]   tcdm_add_i,
    input  logic            tcdm_wen_i,
    input  logic [BW/8-1:0] tcdm_be_i,
    input  logic [BW-1:0]   tcdm_data_i,
    output logic [BW-1:0]   tcdm_r_data_o,
    output logic            tcdm_r_valid_o,
    output logic            busy_o,
    output logic            err_o
);

    localparam int unsigned NB   = BW / 8;
    localparam int unsigned OFFS = $clog2(NB);
    localparam int unsigned IW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CW   = (GNT_STALL_EVERY > 0) ? $clog2(GNT_STALL_EVERY + 1) : 1;

    logic [BW-1:0]              mem [MEM_WORDS];
    logic [LATENCY-1:0]         vld_pipe;
    logic [LATENCY-1:0][BW-1:0] data_pipe;
    logic                       stall_q;
    logic                       err_q;
    logic                       accept;
    logic                       out_of_range;
    logic                       push;
    logic [BW-1:0]              push_data;
    logic [IW-1:0]              word_idx;
    logic                       unused_addr_lsb;

    // Clear wins over everything so nothing slips in while the pipeline is being flushed.
    assign tcdm_gnt_o = enable_i & ~stall_q & ~clear_i;
    assign accept     = tcdm_req_i & tcdm_gnt_o;

    // Sub-word byte offset bits carry no information for a word-wide port.
    assign unused_addr_lsb = ^tcdm_add_i[OFFS-1:0];
    assign word_idx        = tcdm_add_i[OFFS +: IW];

    if (AW > OFFS + IW) begin : g_oor
        assign out_of_range = |tcdm_add_i[AW-1:OFFS+IW];
    end else begin : g_no_oor
        assign out_of_range = 1'b0;
    end

    // Loads always respond; stores respond (with zero data) only when acknowledgements are on.
    assign push      = accept & (tcdm_wen_i | (WRITE_RVALID != 0));
    assign push_data = (tcdm_wen_i && !out_of_range) ? mem[word_idx] : '0;

    always_ff @(posedge clk_i) begin
        if (accept && !tcdm_wen_i && !out_of_range) begin
            for (int b = 0; b < NB; b++) begin
                if (tcdm_be_i[b]) mem[word_idx][b*8 +: 8] <= tcdm_data_i[b*8 +: 8];
            end
        end
    end

    // Data registers only move with a valid entry, so the last stage holds r_data between pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else if (clear_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= push;
            if (push) data_pipe[0] <= push_data;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                       err_q <= 1'b0;
        else if (clear_i)                err_q <= 1'b0;
        else if (accept && out_of_range) err_q <= 1'b1;
    end

    if (GNT_STALL_EVERY > 0) begin : g_stall
        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q   <= '0;
                stall_q <= 1'b0;
            end else if (clear_i) begin
                cnt_q   <= '0;
                stall_q <= 1'b0;
            end else begin
                stall_q <= 1'b0;
                if (accept) begin
                    if (cnt_q == CW'(GNT_STALL_EVERY - 1)) begin
                        cnt_q   <= '0;
                        stall_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            end
        end
    end else begin : g_no_stall
        assign stall_q = 1'b0;
    end

    assign tcdm_r_valid_o = vld_pipe[LATENCY-1];
    assign tcdm_r_data_o  = data_pipe[LATENCY-1];
    assign busy_o         = |vld_pipe;
    assign err_o          = err_q;

endmodule
